// File: rtl/nic_vc_allocator_pkg.sv
// -----------------------------------------------------------------------------
// nic_vc_allocator_pkg
// Shared NIC constants and VC-allocation helpers. These are the NIC-wide
// definitions: VN/VC counts, flit width and a clog2 constant function.
// A VC with global index i belongs to VN i / N_OF_VC.
// -----------------------------------------------------------------------------
package nic_vc_allocator_pkg;

  localparam int N_OF_VN       = 2;
  localparam int N_OF_VC       = 3;
  localparam int N_TOT_OF_VC   = N_OF_VC * N_OF_VN;
  localparam int N_FIFO_BUFFER = 8;
  localparam int FLIT_WIDTH    = 32;

  // ceil(log2(value)), never below 1 so that every field has at least one bit
  function automatic int clog2_min1(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      result = ((32'sd1 << i) < value) ? (i + 1) : result;
    end
    return result;
  endfunction

  localparam int N_BITS_POINTER = clog2_min1(N_FIFO_BUFFER);
  localparam int N_BITS_VN      = clog2_min1(N_OF_VN);
  localparam int N_BITS_VC      = clog2_min1(N_TOT_OF_VC);
  localparam int N_ID_W         = N_TOT_OF_VC * N_BITS_POINTER;

  // True when the VN field names an existing virtual network
  function automatic logic vn_is_valid(input logic [N_BITS_VN-1:0] vn);
    return (int'(vn) < N_OF_VN);
  endfunction

  // True when at least one usable VC exists inside the given VN
  function automatic logic vn_has_vc(input logic [N_TOT_OF_VC-1:0] vc_ok,
                                     input logic [N_BITS_VN-1:0]   vn);
    logic has;
    has = 1'b0;
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      has = has | (vc_ok[i] & ((i / N_OF_VC) == int'(vn)));
    end
    return has & vn_is_valid(vn);
  endfunction

  // Lowest-index usable VC inside the given VN (0 when none)
  function automatic logic [N_BITS_VC-1:0] lowest_vc_in_vn(
      input logic [N_TOT_OF_VC-1:0] vc_ok,
      input logic [N_BITS_VN-1:0]   vn);
    logic [N_BITS_VC-1:0] idx;
    idx = {N_BITS_VC{1'b0}};
    // Scan downward so the last match written is the lowest index
    for (int i = N_TOT_OF_VC - 1; i >= 0; i--) begin
      idx = (vc_ok[i] && ((i / N_OF_VC) == int'(vn))) ? N_BITS_VC'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/nic_vc_allocator_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nic_rr_arbiter
// Combinational round-robin arbiter. The search starts at i_ptr and wraps
// around; the first requester found wins. The pointer register lives in
// the parent.
// Ports:
//   i_req  [N]  request vector
//   i_ptr  [W]  index with highest priority this cycle
//   o_gnt  [N]  one-hot grant, all zero when no request
//   o_idx  [W]  binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module nic_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx
);

  logic w_found;
  int   w_pos;

  // Rotating priority search starting at i_ptr
  always_comb begin
    o_gnt   = {N{1'b0}};
    o_idx   = {W{1'b0}};
    w_found = 1'b0;
    w_pos   = 0;
    for (int i = 0; i < N; i++) begin
      w_pos = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_pos]) begin
        o_gnt[w_pos] = 1'b1;
        o_idx        = W'(w_pos);
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/nic_vc_allocator.sv
// -----------------------------------------------------------------------------
// nic_vc_allocator
// VC allocator on the NIC injection path. Each cycle one requesting output
// buffer is chosen round-robin and given the lowest free, idle VC of its
// VN. The decision is registered: all outputs are flops and each grant is
// held for exactly one cycle.
//
// Optional build macro NIC_VA_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of cycles where some buffer requested but nothing was granted.
//
// Ports:
//   clk, rst                synchronous active-high reset
//   req_i                   buffer b holds a head flit needing a VC
//   req_vn_i                VN of buffer b in slice b
//   fifo_pointer_state_i    1 = pointer busy (from fifo_nic2noc)
//   free_signal_i           1 = downstream VC free
//   g_fifo_pointer_o        one-hot VC grant
//   g_fifo_out_buffer_id_o  winning buffer id in the granted VC's slice
//   grant_o                 one-hot buffer grant
//   grant_vc_o              index of granted VC, valid while grant_o != 0
//   stall_cnt_o             (NIC_VA_STALL_CNT_EN only) stall cycle count
// -----------------------------------------------------------------------------
module nic_vc_allocator
  import nic_vc_allocator_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_FIFO_BUFFER-1:0]             req_i,
  input  logic [N_FIFO_BUFFER*N_BITS_VN-1:0]   req_vn_i,
  input  logic [N_TOT_OF_VC-1:0]               fifo_pointer_state_i,
  input  logic [N_TOT_OF_VC-1:0]               free_signal_i,
  output logic [N_TOT_OF_VC-1:0]               g_fifo_pointer_o,
  output logic [N_ID_W-1:0]                    g_fifo_out_buffer_id_o,
  output logic [N_FIFO_BUFFER-1:0]             grant_o,
  output logic [N_BITS_VC-1:0]                 grant_vc_o
`ifdef NIC_VA_STALL_CNT_EN
  ,
  output logic [15:0]                          stall_cnt_o
`endif
);

  logic [N_TOT_OF_VC-1:0]    r_g_fifo_pointer;
  logic [N_ID_W-1:0]         r_buffer_id;
  logic [N_FIFO_BUFFER-1:0]  r_grant;
  logic [N_BITS_VC-1:0]      r_grant_vc;
  logic [N_BITS_POINTER-1:0] r_rr_ptr;

  logic [N_TOT_OF_VC-1:0]    w_vc_ok;
  logic [N_FIFO_BUFFER-1:0]  w_buf_ok;
  logic [N_FIFO_BUFFER-1:0]  w_arb_gnt;
  logic [N_BITS_POINTER-1:0] w_win_idx;
  logic [N_BITS_VN-1:0]      w_win_vn;
  logic [N_BITS_VC-1:0]      w_win_vc;
  logic                      w_any_grant;

  logic [N_TOT_OF_VC-1:0]    w_nxt_g_ptr;
  logic [N_ID_W-1:0]         w_nxt_id;
  logic [N_FIFO_BUFFER-1:0]  w_nxt_grant;
  logic [N_BITS_VC-1:0]      w_nxt_vc;
  logic [N_BITS_POINTER-1:0] w_nxt_rr;

  // Usable VCs and eligible buffers. The registered grants mask the VC and
  // buffer granted last cycle, since upstream has not yet reacted to them.
  always_comb begin
    w_vc_ok  = ~fifo_pointer_state_i & free_signal_i & ~r_g_fifo_pointer;
    w_buf_ok = {N_FIFO_BUFFER{1'b0}};
    for (int b = 0; b < N_FIFO_BUFFER; b++) begin
      w_buf_ok[b] = req_i[b] & ~r_grant[b]
                  & vn_has_vc(w_vc_ok, req_vn_i[b*N_BITS_VN +: N_BITS_VN]);
    end
  end

  nic_rr_arbiter #(
    .N (N_FIFO_BUFFER),
    .W (N_BITS_POINTER)
  ) u_rr_arbiter (
    .i_req (w_buf_ok),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_win_idx)
  );

  // Next-cycle grant and pointer derived from the arbiter winner
  always_comb begin
    w_any_grant = |w_buf_ok;
    w_win_vn    = req_vn_i[w_win_idx*N_BITS_VN +: N_BITS_VN];
    w_win_vc    = lowest_vc_in_vn(w_vc_ok, w_win_vn);
    w_nxt_g_ptr = {N_TOT_OF_VC{1'b0}};
    w_nxt_id    = {N_ID_W{1'b0}};
    w_nxt_grant = {N_FIFO_BUFFER{1'b0}};
    w_nxt_vc    = {N_BITS_VC{1'b0}};
    w_nxt_rr    = r_rr_ptr;
    if (w_any_grant) begin
      w_nxt_g_ptr = N_TOT_OF_VC'(1) << w_win_vc;
      w_nxt_id    = N_ID_W'(w_win_idx) << (int'(w_win_vc) * N_BITS_POINTER);
      w_nxt_grant = w_arb_gnt;
      w_nxt_vc    = w_win_vc;
      w_nxt_rr    = (int'(w_win_idx) == (N_FIFO_BUFFER - 1)) ?
                    {N_BITS_POINTER{1'b0}} : (w_win_idx + N_BITS_POINTER'(1));
    end else begin
      w_nxt_rr = r_rr_ptr;
    end
  end

  // Output and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_fifo_pointer <= {N_TOT_OF_VC{1'b0}};
      r_buffer_id      <= {N_ID_W{1'b0}};
      r_grant          <= {N_FIFO_BUFFER{1'b0}};
      r_grant_vc       <= {N_BITS_VC{1'b0}};
      r_rr_ptr         <= {N_BITS_POINTER{1'b0}};
    end else begin
      r_g_fifo_pointer <= w_nxt_g_ptr;
      r_buffer_id      <= w_nxt_id;
      r_grant          <= w_nxt_grant;
      r_grant_vc       <= w_nxt_vc;
      r_rr_ptr         <= w_nxt_rr;
    end
  end

  assign g_fifo_pointer_o       = r_g_fifo_pointer;
  assign g_fifo_out_buffer_id_o = r_buffer_id;
  assign grant_o                = r_grant;
  assign grant_vc_o             = r_grant_vc;

`ifdef NIC_VA_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles with a pending request but no grant decision
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if ((|req_i) && !w_any_grant && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_nic_vc_allocator.sv
module tb_nic_vc_allocator;
  import nic_vc_allocator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                               rst;
  logic [N_FIFO_BUFFER-1:0]           req_i;
  logic [N_FIFO_BUFFER*N_BITS_VN-1:0] req_vn_i;
  logic [N_TOT_OF_VC-1:0]             fifo_pointer_state_i;
  logic [N_TOT_OF_VC-1:0]             free_signal_i;
  logic [N_TOT_OF_VC-1:0]             g_fifo_pointer_o;
  logic [N_ID_W-1:0]                  g_fifo_out_buffer_id_o;
  logic [N_FIFO_BUFFER-1:0]           grant_o;
  logic [N_BITS_VC-1:0]               grant_vc_o;
`ifdef NIC_VA_STALL_CNT_EN
  logic [15:0]                        stall_cnt_o;
`endif

  nic_vc_allocator dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_i                  (req_i),
    .req_vn_i               (req_vn_i),
    .fifo_pointer_state_i   (fifo_pointer_state_i),
    .free_signal_i          (free_signal_i),
    .g_fifo_pointer_o       (g_fifo_pointer_o),
    .g_fifo_out_buffer_id_o (g_fifo_out_buffer_id_o),
    .grant_o                (grant_o),
    .grant_vc_o             (grant_vc_o)
`ifdef NIC_VA_STALL_CNT_EN
    ,
    .stall_cnt_o            (stall_cnt_o)
`endif
  );

  typedef struct {
    int                       tag;
    int                       exp_cyc;
    logic [N_FIFO_BUFFER-1:0] grant;
    logic [N_TOT_OF_VC-1:0]   gptr;
    logic [N_ID_W-1:0]        id;
    logic [N_BITS_VC-1:0]     vc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // cycle counter: number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // apply one cycle of stimulus just after a rising edge
  task automatic drive(input logic r, input logic [7:0] rq, input logic [7:0] vn,
                       input logic [5:0] st, input logic [5:0] fr);
    @(posedge clk);
    #1;
    rst                  = r;
    req_i                = rq;
    req_vn_i             = vn;
    fifo_pointer_state_i = st;
    free_signal_i        = fr;
  endtask

  // the decision on the stimulus just driven shows up after the next edge
  task automatic expect_grant(input int tag, input int w, input int v);
    exp_t e;
    e.tag     = tag;
    e.exp_cyc = cyc + 1;
    e.grant   = N_FIFO_BUFFER'(1) << w;
    e.gptr    = N_TOT_OF_VC'(1) << v;
    e.id      = N_ID_W'(w) << (v * N_BITS_POINTER);
    e.vc      = N_BITS_VC'(v);
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compares every presented grant against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].exp_cyc < cyc) begin
        e = sb_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_grant tag%0d: got nothing by cycle %0d expected grant %0h at cycle %0d",
                 e.tag, cyc, e.grant, e.exp_cyc);
      end
      if (grant_o != '0) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_grant: got grant %0h vc %0d at cycle %0d expected none",
                   grant_o, grant_vc_o, cyc);
        end else begin
          e = sb_q.pop_front();
          if (cyc != e.exp_cyc || grant_o !== e.grant || g_fifo_pointer_o !== e.gptr ||
              g_fifo_out_buffer_id_o !== e.id || grant_vc_o !== e.vc) begin
            n_fail++;
            $display("FAIL grant tag%0d: got cyc %0d grant %0h gptr %0h id %0h vc %0d expected cyc %0d grant %0h gptr %0h id %0h vc %0d",
                     e.tag, cyc, grant_o, g_fifo_pointer_o, g_fifo_out_buffer_id_o, grant_vc_o,
                     e.exp_cyc, e.grant, e.gptr, e.id, e.vc);
          end
        end
      end else if (g_fifo_pointer_o != '0 || g_fifo_out_buffer_id_o != '0 || grant_vc_o != '0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_output: got gptr %0h id %0h vc %0d with grant_o 0 expected all 0",
                 g_fifo_pointer_o, g_fifo_out_buffer_id_o, grant_vc_o);
      end
    end
  end

  initial begin
    rst                  = 1'b1;
    req_i                = '0;
    req_vn_i             = '0;
    fifo_pointer_state_i = '0;
    free_signal_i        = 6'h3F;

    // reset, then idle with all VCs free: nothing must be granted
    repeat (3) drive(1'b1, 8'h00, 8'h00, 6'h00, 6'h3F);
    repeat (10) drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);
    @(negedge clk);
    check("reset_grant", 32'(grant_o), 32'h0);
    check("reset_gptr", 32'(g_fifo_pointer_o), 32'h0);
    check("reset_id", 32'(g_fifo_out_buffer_id_o), 32'h0);
    check("reset_vc", 32'(grant_vc_o), 32'h0);
    check("reset_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);

    // single request on buffer 0, held a second cycle: only one grant
    drive(1'b0, 8'h01, 8'h00, 6'h00, 6'h3F); expect_grant(1, 0, 0);
    drive(1'b0, 8'h01, 8'h00, 6'h00, 6'h3F);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);

    // buffers 0 and 7 from pointer 0: buffer 0 on VC0, then 7 on VC1, pointer wraps
    drive(1'b1, 8'h00, 8'h00, 6'h00, 6'h3F);
    drive(1'b0, 8'h81, 8'h00, 6'h00, 6'h3F); expect_grant(2, 0, 0);
    drive(1'b0, 8'h81, 8'h00, 6'h00, 6'h3F); expect_grant(3, 7, 1);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);
    @(negedge clk);
    check("rr_wrap_ptr", 32'(dut.r_rr_ptr), 32'h0);

    // buffer 2 in VN1 with VCs 3-5 busy: wait, then VC4 released
    drive(1'b0, 8'h04, 8'h04, 6'h38, 6'h3F);
    drive(1'b0, 8'h04, 8'h04, 6'h38, 6'h3F);
    drive(1'b0, 8'h04, 8'h04, 6'h28, 6'h3F); expect_grant(4, 2, 4);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);

    // VC0 not free downstream: buffer 1 (VN0) must get VC1
    drive(1'b0, 8'h02, 8'h00, 6'h00, 6'h3E); expect_grant(5, 1, 1);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);

    // pointer 2, buffers 1 (VN0) and 3 (VN1): 3 first on VC3, then 1 on VC0
    drive(1'b0, 8'h0A, 8'h08, 6'h00, 6'h3F); expect_grant(6, 3, 3);
    drive(1'b0, 8'h0A, 8'h08, 6'h00, 6'h3F); expect_grant(7, 1, 0);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);

    // only VC0 idle in VN0: after granting it, VN0 stalls one cycle, then buffer 5
    drive(1'b0, 8'h30, 8'h00, 6'h06, 6'h3F); expect_grant(8, 4, 0);
    drive(1'b0, 8'h30, 8'h00, 6'h06, 6'h3F);
    drive(1'b0, 8'h30, 8'h00, 6'h06, 6'h3F); expect_grant(9, 5, 0);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);
    @(negedge clk);
    check("rr_after_b5", 32'(dut.r_rr_ptr), 32'h6);

    // reset together with an eligible request: no grant, pointer back to 0
    drive(1'b1, 8'h01, 8'h00, 6'h00, 6'h3F);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);
    @(negedge clk);
    check("midrst_grant", 32'(grant_o), 32'h0);
    check("midrst_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);

`ifdef NIC_VA_STALL_CNT_EN
    // every VC busy with buffer 0 requesting: counter saturates
    drive(1'b1, 8'h00, 8'h00, 6'h00, 6'h3F);
    drive(1'b0, 8'h01, 8'h00, 6'h3F, 6'h3F);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("stall_saturate", 32'(stall_cnt_o), 32'hFFFF);
    drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);
`endif

    repeat (3) drive(1'b0, 8'h00, 8'h00, 6'h00, 6'h3F);
    @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
